// File: rtl/qc_ldpc_pkg.sv
// Shared definitions for the quasi-cyclic LDPC encoder.
//   GROUPS_TBL : info-group count per code-rate mode (0 or out of range -> MAX_GROUPS)
//   state_e    : encoder FSM states
//   rotr1      : rotate-right-by-one over the low w bits of a wide vector
//   rom_aw     : address width of the circulant-row ROM
package qc_ldpc_pkg;

  localparam int unsigned TBL_MODES = 2;
  localparam int unsigned GROUPS_TBL [TBL_MODES] = '{3, 2};

  // Widest circulant the shared rotate helper supports.
  localparam int unsigned ROT_MAX_W = 1024;

  typedef enum logic [1:0] {IDLE, FETCH, INFO, PARITY} state_e;

  // Group count for a mode, with illegal table entries mapped to max_groups so
  // a bad table entry can never stall the frame.
  function automatic int unsigned groups_for(input int unsigned mode,
                                             input int unsigned max_groups);
    int unsigned g;
    g = 0;
    for (int i = 0; i < TBL_MODES; i++) begin
      if (mode == i) g = GROUPS_TBL[i];
    end
    if (g == 0 || g > max_groups) g = max_groups;
    return g;
  endfunction

  // {v[0], v[w-1:1]}; bits at or above w must be zero on entry.
  function automatic logic [ROT_MAX_W-1:0] rotr1(input logic [ROT_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [ROT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < ROT_MAX_W - 1; i++) r[i] = v[i+1];
    r[w-1] = v[0];
    return r;
  endfunction

  function automatic int unsigned rom_aw(input int unsigned num_modes,
                                         input int unsigned max_groups);
    return (num_modes * max_groups > 1) ? $clog2(num_modes * max_groups) : 1;
  endfunction

endpackage

// File: rtl/qc_ldpc_encoder_qc_row_rom.sv
// Circulant first-row ROM, synchronous read with one cycle of latency.
// Contents come from the INIT parameter (generated per Z); row r sits at
// INIT[r*Z +: Z] with r = mode*MAX_GROUPS + group.
//   clk    in   clock
//   addr   in   row address
//   rom_q  out  registered row, valid the cycle after addr is presented
module qc_row_rom
  import qc_ldpc_pkg::*;
#(
  parameter int unsigned Z     = 360,
  parameter int unsigned DEPTH = 24,
  parameter int unsigned AW    = rom_aw(DEPTH, 1),
  parameter logic [DEPTH*Z-1:0] INIT = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [Z-1:0]  rom_q
);

  logic [Z-1:0] rom_d;

  always_comb begin
    rom_d = '0;
    if (32'(addr) < DEPTH) rom_d = INIT[32'(addr) * Z +: Z];
  end

  always_ff @(posedge clk) begin
    rom_q <= rom_d;
  end

endmodule

// File: rtl/qc_ldpc_encoder.sv
// Quasi-cyclic LDPC systematic encoder. Info bits stream in serially, are
// forwarded unchanged, and each 1-bit XORs the current rotated circulant row
// into a Z-bit parity accumulator; the Z parity bits follow, MSB first.
// Requires Z >= 3 so the next group's row is prefetched before it is needed.
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  code-rate select, sampled with the accepted s_sof bit
//   s_valid/s_ready       info-bit handshake; s_data bit, s_sof first bit of frame
//   m_valid/m_ready       output handshake; m_data bit, m_parity parity phase,
//                         m_last final parity bit
//   busy                  frame in progress
//   err_sof               one-cycle pulse when s_sof arrives mid-frame
module qc_ldpc_encoder
  import qc_ldpc_pkg::*;
#(
  parameter int unsigned Z          = 360,
  parameter int unsigned MAX_GROUPS = 12,
  parameter int unsigned NUM_MODES  = 2,
  parameter int unsigned MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  parameter logic [NUM_MODES*MAX_GROUPS*Z-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_data,
  output logic              m_parity,
  output logic              m_last,
  output logic              busy,
  output logic              err_sof
);

  localparam int unsigned DEPTH = NUM_MODES * MAX_GROUPS;
  localparam int unsigned AW    = rom_aw(NUM_MODES, MAX_GROUPS);
  localparam int unsigned JW    = (Z > 1) ? $clog2(Z) : 1;
  localparam int unsigned GW    = $clog2(MAX_GROUPS + 1);
  localparam logic [JW-1:0] J_LAST = JW'(Z - 1);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [GW-1:0]     grp_n_q, grp_n_d;
  logic [GW-1:0]     g_q, g_d;
  logic [JW-1:0]     j_q, j_d;
  logic [JW-1:0]     p_q, p_d;
  logic [Z-1:0]      row_q, row_d;
  logic [Z-1:0]      next_row_q, next_row_d;
  logic [Z-1:0]      acc_q, acc_d;
  logic              m_valid_q, m_valid_d;
  logic              m_data_q, m_data_d;
  logic              m_parity_q, m_parity_d;
  logic              m_last_q, m_last_d;
  logic              err_sof_q, err_sof_d;
  logic [AW-1:0]     rom_addr;
  logic [Z-1:0]      rom_q;
  logic              out_free;

  function automatic logic [Z-1:0] rotr_z(input logic [Z-1:0] v);
    logic [ROT_MAX_W-1:0] w;
    w = '0;
    w[Z-1:0] = v;
    w = rotr1(w, Z);
    return w[Z-1:0];
  endfunction

  // Row address within the mode's block; groups past the end clamp to the last row.
  function automatic logic [AW-1:0] rom_index(input logic [MODE_W-1:0] m,
                                              input int unsigned g);
    int unsigned idx;
    idx = 32'(m) * MAX_GROUPS + ((g < MAX_GROUPS) ? g : MAX_GROUPS - 1);
    return idx[AW-1:0];
  endfunction

  qc_row_rom #(
    .Z     (Z),
    .DEPTH (DEPTH),
    .AW    (AW),
    .INIT  (ROM_INIT)
  ) u_rom (
    .clk   (clk),
    .addr  (rom_addr),
    .rom_q (rom_q)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    grp_n_d    = grp_n_q;
    g_d        = g_q;
    j_d        = j_q;
    p_d        = p_q;
    row_d      = row_q;
    next_row_d = next_row_q;
    acc_d      = acc_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_parity_d = m_parity_q;
    m_last_d   = m_last_q;
    err_sof_d  = 1'b0;
    s_ready    = 1'b0;
    rom_addr   = rom_index(mode_q, 32'(g_q) + 1);
    out_free   = !m_valid_q || m_ready;

    // A consumed output drops valid unless a new bit is loaded below.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        rom_addr = rom_index(mode, 0);
        if (s_valid && s_sof && out_free) begin
          s_ready    = 1'b1;
          mode_d     = mode;
          grp_n_d    = GW'(groups_for(32'(mode), MAX_GROUPS));
          g_d        = '0;
          j_d        = '0;
          acc_d      = '0;
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          m_parity_d = 1'b0;
          m_last_d   = 1'b0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // Bit 0 was taken while the row was still in flight; m_data_q still
        // holds it, so it is folded in here using the row straight off the ROM.
        acc_d   = m_data_q ? rom_q : '0;
        row_d   = rotr_z(rom_q);
        j_d     = JW'(1);
        state_d = INFO;
      end
      INFO: begin
        next_row_d = rom_q;
        s_ready    = out_free;
        if (s_valid && out_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          m_parity_d = 1'b0;
          err_sof_d  = s_sof;
          if (s_data) acc_d = acc_q ^ row_q;
          if (j_q == J_LAST) begin
            row_d = next_row_q;
            j_d   = '0;
            g_d   = g_q + GW'(1);
            if (g_q == grp_n_q - GW'(1)) begin
              g_d     = '0;
              p_d     = J_LAST;
              state_d = PARITY;
            end
          end else begin
            row_d = rotr_z(row_q);
            j_d   = j_q + JW'(1);
          end
        end
      end
      PARITY: begin
        if (m_last_q) begin
          if (m_ready) begin
            m_parity_d = 1'b0;
            m_last_d   = 1'b0;
            state_d    = IDLE;
          end
        end else if (out_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = acc_q[p_q];
          m_parity_d = 1'b1;
          m_last_d   = (p_q == '0);
          if (p_q != '0) p_d = p_q - JW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      grp_n_q    <= '0;
      g_q        <= '0;
      j_q        <= '0;
      p_q        <= '0;
      row_q      <= '0;
      next_row_q <= '0;
      acc_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 1'b0;
      m_parity_q <= 1'b0;
      m_last_q   <= 1'b0;
      err_sof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      grp_n_q    <= grp_n_d;
      g_q        <= g_d;
      j_q        <= j_d;
      p_q        <= p_d;
      row_q      <= row_d;
      next_row_q <= next_row_d;
      acc_q      <= acc_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_parity_q <= m_parity_d;
      m_last_q   <= m_last_d;
      err_sof_q  <= err_sof_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_parity = m_parity_q;
  assign m_last   = m_last_q;
  assign err_sof  = err_sof_q;
  assign busy     = (state_q != IDLE);

endmodule
